// File: rtl/pivot_axil_pkg.sv
// Shared types, register map constants and the byte-strobe merge helper
// for the PIVOT AXI4-Lite register bank.
package pivot_axil_pkg;

   typedef logic [1:0] axi_resp_t;
   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {WIDLE, WACK, WRESP} wr_state_t;
   typedef enum logic [1:0] {RIDLE, RACK, RDATA} rd_state_t;

   localparam logic [4:0] ADDR_CFG0   = 5'h00;
   localparam logic [4:0] ADDR_CTRL   = 5'h10;
   localparam logic [4:0] ADDR_STATUS = 5'h14;

   localparam int unsigned ST_BUSY = 0;
   localparam int unsigned ST_DONE = 1;
   localparam int unsigned ST_OVR  = 2;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_v;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_v[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/pivot_axil_regs_if.sv
// AXI4-Lite bus bundle between the PIVOT AXI master and the register bank.
interface pivot_axil_regs_if #(
   parameter int unsigned C_ADDR_WIDTH = 5,
   parameter int unsigned C_DATA_WIDTH = 32
);
   logic [C_ADDR_WIDTH-1:0]   s_awaddr;
   logic [2:0]                s_awprot;
   logic                      s_awvalid;
   logic                      s_awready;
   logic [C_DATA_WIDTH-1:0]   s_wdata;
   logic [C_DATA_WIDTH/8-1:0] s_wstrb;
   logic                      s_wvalid;
   logic                      s_wready;
   logic [1:0]                s_bresp;
   logic                      s_bvalid;
   logic                      s_bready;
   logic [C_ADDR_WIDTH-1:0]   s_araddr;
   logic [2:0]                s_arprot;
   logic                      s_arvalid;
   logic                      s_arready;
   logic [C_DATA_WIDTH-1:0]   s_rdata;
   logic [1:0]                s_rresp;
   logic                      s_rvalid;
   logic                      s_rready;

   modport master (
      output s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arprot, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
   );

   modport slave (
      input  s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arprot, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
   );
endinterface

// File: rtl/pivot_axil_regs.sv
// AXI4-Lite register bank for the PIVOT core: CFG0..3, CTRL start, STATUS.
// Optional macro PIVOT_AXIL_SLVERR_EN: SLVERR response for 0x18/0x1C.
module pivot_axil_regs
   import pivot_axil_pkg::*;
#(
   parameter int unsigned C_DATA_WIDTH = 32,
   parameter int unsigned C_ADDR_WIDTH = 5,
   parameter int unsigned NUM_CFG      = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   pivot_axil_regs_if.slave         s_axil,
   output logic [NUM_CFG*32-1:0]    cfg_o,
   output logic                     start_o,
   input  logic                     busy_i,
   input  logic                     done_i
);

   wr_state_t   wr_state, wr_state_nxt;
   rd_state_t   rd_state, rd_state_nxt;
   logic [31:0] cfg [NUM_CFG];
   logic        done_sticky;
   logic        overrun;
   logic [2:0]  wr_word;
   logic [2:0]  rd_word;
   logic        wr_en;
   logic        ctrl_start;
   logic        wr_status;
   logic [31:0] rd_mux;

   // ---------------- write channel ----------------
   always_ff @(posedge clock) begin
      if (reset) wr_state <= WIDLE;
      else       wr_state <= wr_state_nxt;
   end

   always_comb begin
      wr_state_nxt     = wr_state;
      s_axil.s_awready = 1'b0;
      s_axil.s_wready  = 1'b0;
      s_axil.s_bvalid  = 1'b0;
      case (wr_state)
         WIDLE: if (s_axil.s_awvalid && s_axil.s_wvalid) wr_state_nxt = WACK;
         WACK: begin
            s_axil.s_awready = 1'b1;
            s_axil.s_wready  = 1'b1;
            wr_state_nxt     = WRESP;
         end
         WRESP: begin
            s_axil.s_bvalid = 1'b1;
            if (s_axil.s_bready) wr_state_nxt = WIDLE;
         end
         default: wr_state_nxt = WIDLE;
      endcase
   end

   assign wr_en      = (wr_state == WACK);
   assign wr_word    = s_axil.s_awaddr[4:2];
   assign ctrl_start = wr_en && (wr_word == ADDR_CTRL[4:2]) &&
                       s_axil.s_wdata[0] && s_axil.s_wstrb[0];
   assign wr_status  = wr_en && (wr_word == ADDR_STATUS[4:2]) && s_axil.s_wstrb[0];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned k = 0; k < NUM_CFG; k++) cfg[k] <= '0;
      end else if (wr_en) begin
         for (int unsigned k = 0; k < NUM_CFG; k++) begin
            if (wr_word == 3'(k))
               cfg[k] <= strb_merge(cfg[k], s_axil.s_wdata, s_axil.s_wstrb);
         end
      end
   end

   always_comb begin
      cfg_o = '0;
      for (int unsigned k = 0; k < NUM_CFG; k++) cfg_o[32*k +: 32] = cfg[k];
   end

   // A start request is refused while the core is busy or a pulse is still out;
   // a done pulse outranks a same-cycle W1C clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         start_o     <= 1'b0;
         done_sticky <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         start_o <= ctrl_start && !busy_i && !start_o;
         if (ctrl_start && (busy_i || start_o))
            overrun <= 1'b1;
         else if (wr_status && s_axil.s_wdata[ST_OVR])
            overrun <= 1'b0;
         if (done_i)
            done_sticky <= 1'b1;
         else if (wr_status && s_axil.s_wdata[ST_DONE])
            done_sticky <= 1'b0;
      end
   end

   // ---------------- read channel ----------------
   always_ff @(posedge clock) begin
      if (reset) rd_state <= RIDLE;
      else       rd_state <= rd_state_nxt;
   end

   always_comb begin
      rd_state_nxt     = rd_state;
      s_axil.s_arready = 1'b0;
      s_axil.s_rvalid  = 1'b0;
      case (rd_state)
         RIDLE: if (s_axil.s_arvalid) rd_state_nxt = RACK;
         RACK: begin
            s_axil.s_arready = 1'b1;
            rd_state_nxt     = RDATA;
         end
         RDATA: begin
            s_axil.s_rvalid = 1'b1;
            if (s_axil.s_rready) rd_state_nxt = RIDLE;
         end
         default: rd_state_nxt = RIDLE;
      endcase
   end

   assign rd_word = s_axil.s_araddr[4:2];

   always_comb begin
      rd_mux = '0;
      for (int unsigned k = 0; k < NUM_CFG; k++) begin
         if (rd_word == 3'(k)) rd_mux = cfg[k];
      end
      if (rd_word == ADDR_STATUS[4:2]) begin
         rd_mux[ST_BUSY] = busy_i;
         rd_mux[ST_DONE] = done_sticky;
         rd_mux[ST_OVR]  = overrun;
      end
   end

   // Captured on the address-accept edge, so a write landing in the same
   // cycle is not yet visible in the returned data.
   always_ff @(posedge clock) begin
      if (reset)                 s_axil.s_rdata <= '0;
      else if (rd_state == RACK) s_axil.s_rdata <= rd_mux;
   end

`ifdef PIVOT_AXIL_SLVERR_EN
   axi_resp_t bresp_q, rresp_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         bresp_q <= RESP_OKAY;
         rresp_q <= RESP_OKAY;
      end else begin
         if (wr_en)
            bresp_q <= (wr_word[2:1] == 2'b11) ? RESP_SLVERR : RESP_OKAY;
         if (rd_state == RACK)
            rresp_q <= (rd_word[2:1] == 2'b11) ? RESP_SLVERR : RESP_OKAY;
      end
   end

   assign s_axil.s_bresp = bresp_q;
   assign s_axil.s_rresp = rresp_q;
`else
   assign s_axil.s_bresp = RESP_OKAY;
   assign s_axil.s_rresp = RESP_OKAY;
`endif

endmodule

// File: tb/tb_pivot_axil_regs.sv
// Self-checking bench for pivot_axil_regs: directed cases plus randomized
// accesses checked against a word/byte-level register model.
module tb_pivot_axil_regs;

   logic         clock = 1'b0;
   logic         reset;
   logic [127:0] cfg_o;
   logic         start_o;
   logic         busy_i;
   logic         done_i;

   int unsigned  checks = 0;
   int unsigned  errors = 0;

   logic [31:0]  m_cfg [4];
   logic         m_done;
   logic         m_ovr;

   pivot_axil_regs_if #(.C_ADDR_WIDTH(5), .C_DATA_WIDTH(32)) axil ();

   pivot_axil_regs #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(5), .NUM_CFG(4)) dut (
      .clock   (clock),
      .reset   (reset),
      .s_axil  (axil.slave),
      .cfg_o   (cfg_o),
      .start_o (start_o),
      .busy_i  (busy_i),
      .done_i  (done_i)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] addr);
      int unsigned w;
      w = int'(addr) / 4;
      if (w < 4)  return m_cfg[w];
      if (w == 5) return 32'(m_ovr) * 4 + 32'(m_done) * 2 + 32'(busy_i);
      return 32'h0;
   endfunction

   function automatic logic [1:0] model_resp(input logic [4:0] addr);
`ifdef PIVOT_AXIL_SLVERR_EN
      if (int'(addr) >= 'h18) return 2'b10;
`endif
      return 2'b00;
   endfunction

   function automatic logic [127:0] model_cfg();
      return {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_cfg[i] = '0;
      m_done = 1'b0;
      m_ovr  = 1'b0;
   endtask

   task automatic axil_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int unsigned lead,
                             input int unsigned stall, input bit pulse_done);
      int unsigned waited;
      int unsigned w;
      logic [31:0] mask;
      bit          want_start;
      bit          got_ack;
      w = int'(addr) / 4;
      @(negedge clock);
      axil.s_awaddr  = addr;
      axil.s_wdata   = data;
      axil.s_wstrb   = strb;
      axil.s_awvalid = 1'b1;
      axil.s_wvalid  = (lead == 0);
      for (int i = 0; i < int'(lead); i++) begin
         @(negedge clock);
         check("aw_only_no_accept", axil.s_awready, 1'b0);
      end
      axil.s_wvalid = 1'b1;
      waited  = 0;
      got_ack = 0;
      while (!got_ack && waited < 20) begin
         @(negedge clock);
         waited++;
         got_ack = axil.s_awready;
      end
      check("aw_accept_latency", waited, 1);
      check("wready_with_awready", axil.s_wready, 1'b1);
      if (pulse_done) begin
         done_i = 1'b1;
         m_done = 1'b1;
      end
      want_start = (w == 4) && data[0] && strb[0] && !busy_i;
      if ((w == 4) && data[0] && strb[0] && busy_i) m_ovr = 1'b1;
      if (w == 5 && strb[0]) begin
         if (data[1] && !pulse_done) m_done = 1'b0;
         if (data[2])                m_ovr  = 1'b0;
      end
`ifdef PIVOT_AXIL_SLVERR_EN
      if (w < 4) begin
`else
      if (w < 4) begin
`endif
         mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
         m_cfg[w] = (m_cfg[w] & ~mask) | (data & mask);
      end
      @(negedge clock);
      done_i         = 1'b0;
      axil.s_awvalid = 1'b0;
      axil.s_wvalid  = 1'b0;
      check("start_pulse", start_o, want_start);
      check("bvalid_up", axil.s_bvalid, 1'b1);
      check("bresp", axil.s_bresp, model_resp(addr));
      for (int i = 0; i < int'(stall); i++) begin
         @(negedge clock);
         check("bvalid_held", axil.s_bvalid, 1'b1);
         check("awready_blocked", axil.s_awready, 1'b0);
      end
      axil.s_bready = 1'b1;
      @(negedge clock);
      axil.s_bready = 1'b0;
      check("bvalid_drop", axil.s_bvalid, 1'b0);
      check("start_one_cycle", start_o, 1'b0);
   endtask

   task automatic axil_read(input logic [4:0] addr, input int unsigned stall,
                            output logic [31:0] data, output logic [1:0] resp);
      int unsigned waited;
      logic [31:0] first;
      @(negedge clock);
      axil.s_araddr  = addr;
      axil.s_arvalid = 1'b1;
      waited = 0;
      do begin
         @(negedge clock);
         waited++;
      end while (!axil.s_arready && waited < 20);
      check("ar_accept_latency", waited, 1);
      @(negedge clock);
      axil.s_arvalid = 1'b0;
      check("rvalid_up", axil.s_rvalid, 1'b1);
      first = axil.s_rdata;
      for (int i = 0; i < int'(stall); i++) begin
         @(negedge clock);
         check("rdata_stable", axil.s_rdata, first);
      end
      data = axil.s_rdata;
      resp = axil.s_rresp;
      axil.s_rready = 1'b1;
      @(negedge clock);
      axil.s_rready = 1'b0;
      check("rvalid_drop", axil.s_rvalid, 1'b0);
   endtask

   task automatic read_check(input string tag, input logic [4:0] addr);
      logic [31:0] d;
      logic [1:0]  r;
      logic [31:0] exp_d;
      exp_d = model_read(addr);
      axil_read(addr, $urandom_range(0, 2), d, r);
      check(tag, d, exp_d);
      check({tag, "_resp"}, r, model_resp(addr));
   endtask

   initial begin
      logic [4:0]  a;
      logic [31:0] d;
      logic [1:0]  r;

      reset          = 1'b1;
      busy_i         = 1'b0;
      done_i         = 1'b0;
      axil.s_awaddr  = '0;
      axil.s_awprot  = '0;
      axil.s_awvalid = 1'b0;
      axil.s_wdata   = '0;
      axil.s_wstrb   = '0;
      axil.s_wvalid  = 1'b0;
      axil.s_bready  = 1'b0;
      axil.s_araddr  = '0;
      axil.s_arprot  = '0;
      axil.s_arvalid = 1'b0;
      axil.s_rready  = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      reset = 1'b0;

      check("rst_handshake", {axil.s_awready, axil.s_wready, axil.s_bvalid,
                              axil.s_arready, axil.s_rvalid, start_o}, '0);
      check("rst_resp", {axil.s_bresp, axil.s_rresp}, '0);
      check("rst_rdata", axil.s_rdata, '0);
      check("rst_cfg", cfg_o, '0);

      for (int i = 0; i < 4; i++) axil_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) read_check("cfg_readback", 5'(4 * i));
      check("cfg_packed", cfg_o, {32'h4, 32'h3, 32'h2, 32'h1});

      axil_write(5'h04, 32'h11223344, 4'hF, 0, 0, 0);
      axil_write(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
      axil_read(5'h04, 0, d, r);
      check("strobe_merge", d, 32'h11BB33DD);

      axil_write(5'h08, 32'hCAFEF00D, 4'hF, 3, 4, 0);
      read_check("delayed_w", 5'h08);

      busy_i = 1'b0;
      axil_write(5'h10, 32'h1, 4'hF, 0, 1, 0);
      busy_i = 1'b1;
      axil_write(5'h10, 32'h1, 4'hF, 0, 1, 0);
      busy_i = 1'b0;
      axil_read(5'h14, 0, d, r);
      check("overrun_status", d, 32'h4);
      read_check("ctrl_reads_zero", 5'h10);
      axil_write(5'h14, 32'h4, 4'hF, 0, 0, 0);

      @(negedge clock);
      done_i = 1'b1;
      m_done = 1'b1;
      @(negedge clock);
      done_i = 1'b0;
      axil_read(5'h14, 0, d, r);
      check("done_status", d, 32'h2);
      axil_write(5'h14, 32'h2, 4'hF, 0, 0, 1);
      read_check("done_set_wins", 5'h14);
      axil_write(5'h14, 32'h2, 4'hF, 0, 0, 0);
      axil_read(5'h14, 0, d, r);
      check("done_cleared", d, 32'h0);

      axil_write(5'h18, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      axil_write(5'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      axil_read(5'h18, 0, d, r);
      check("unmapped_rdata", d, 32'h0);
      check("unmapped_rresp", r, model_resp(5'h18));
      check("unmapped_no_effect", cfg_o, model_cfg());

      for (int n = 0; n < 60; n++) begin
         busy_i = 1'($urandom_range(0, 1));
         a      = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1)
            axil_write(a, $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 2), $urandom_range(0, 2),
                       1'($urandom_range(0, 3) == 0));
         else
            read_check("rand_read", a);
         check("rand_cfg", cfg_o, model_cfg());
      end
      busy_i = 1'b0;

      @(negedge clock);
      axil.s_awaddr  = 5'h00;
      axil.s_wdata   = 32'h5;
      axil.s_wstrb   = 4'hF;
      axil.s_awvalid = 1'b1;
      axil.s_wvalid  = 1'b1;
      axil.s_araddr  = 5'h00;
      axil.s_arvalid = 1'b1;
      repeat (3) @(negedge clock);
      axil.s_awvalid = 1'b0;
      axil.s_wvalid  = 1'b0;
      axil.s_arvalid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      check("rst_drops_b", axil.s_bvalid, 1'b0);
      check("rst_drops_r", axil.s_rvalid, 1'b0);
      check("rst_clears_cfg", cfg_o, model_cfg());
      read_check("post_rst_read", 5'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
